// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file port D write arbiter.
// Holds the write record layout, the x0 key, the FSM encoding and the filter.
package regfile_write_arbiter_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int KEY_W  = 5;
    localparam int DATA_W = 32;
    localparam int REC_W  = 1 + KEY_W + DATA_W;

    localparam logic [KEY_W-1:0] X0_KEY = '0;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              is_special;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] value;
    } wr_rec_t;

    // Key 0 is the special register; a non-special x0 write is a no-op.
    function automatic logic wr_effective(input wr_rec_t r);
        return r.is_special ? (r.key == X0_KEY) : (r.key != X0_KEY);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the A/B producer inputs and the port D / flow-control outputs.
// master = producer side (writeback, long-latency unit); slave = arbiter.
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 4
);
    import regfile_write_arbiter_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              a_valid;
    logic              a_is_special;
    logic [KEY_W-1:0]  a_dest;
    logic [DATA_W-1:0] a_data;
    logic              a_stall;

    logic              b_valid;
    logic              b_ready;
    logic              b_is_special;
    logic [KEY_W-1:0]  b_dest;
    logic [DATA_W-1:0] b_data;

    logic              portD_enable;
    logic [KEY_W-1:0]  portD_key;
    logic [DATA_W-1:0] portD_value;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output a_valid, a_is_special, a_dest, a_data,
        output b_valid, b_is_special, b_dest, b_data,
        input  a_stall, b_ready,
        input  portD_enable, portD_key, portD_value, fifo_count
    );

    modport slave (
        input  a_valid, a_is_special, a_dest, a_data,
        input  b_valid, b_is_special, b_dest, b_data,
        output a_stall, b_ready,
        output portD_enable, portD_key, portD_value, fifo_count
    );

endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// DEPTH-entry FIFO buffering long-latency write records until port D is free.
// Ports: clk, reset (async active-low), push/wdata, pop/rdata, count/full/empty.
module regfile_write_arbiter_wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; count separates full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares register-file write port D between writeback (A, priority) and a
// FIFO-buffered long-latency unit (B). Ports: clk, reset (async active-low),
// bus (slave modport: A/B requests, a_stall, b_ready, portD_*, fifo_count).
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    wr_rec_t           a_rec;
    wr_rec_t           b_rec;
    wr_rec_t           head;
    logic              a_eff;
    logic              b_eff;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    logic              grant;
    logic [KEY_W-1:0]  win_key;
    logic [DATA_W-1:0] win_value;

    arb_state_e        state;
    arb_state_e        state_nx;
    logic              stall_q;
    logic              stall_nx;
    logic [AGE_W-1:0]  age;
    logic [AGE_W-1:0]  age_nx;

    logic              en_q;
    logic [KEY_W-1:0]  key_q;
    logic [DATA_W-1:0] value_q;

    logic              unused_head_special;

    assign a_rec = '{bus.a_is_special, bus.a_dest, bus.a_data};
    assign b_rec = '{bus.b_is_special, bus.b_dest, bus.b_data};
    assign a_eff = bus.a_valid && wr_effective(a_rec);
    assign b_eff = bus.b_valid && wr_effective(b_rec);

    // Filtered B writes still handshake; they just never enter the FIFO.
    assign bus.b_ready = !full;
    assign push        = bus.b_valid && !full && b_eff;

    // Only effective writes are queued, so the head's flag carries no info.
    assign unused_head_special = head.is_special;

    regfile_write_arbiter_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (b_rec),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Grant: A wins in NORMAL; DRAIN forces the FIFO head out.
    always_comb begin
        grant     = FALSE;
        pop       = FALSE;
        win_key   = a_rec.key;
        win_value = a_rec.value;
        unique case (state)
            NORMAL: begin
                if (a_eff) begin
                    grant = TRUE;
                end else if (!empty) begin
                    grant     = TRUE;
                    pop       = TRUE;
                    win_key   = head.key;
                    win_value = head.value;
                end
            end
            DRAIN: begin
                if (!empty) begin
                    grant     = TRUE;
                    pop       = TRUE;
                    win_key   = head.key;
                    win_value = head.value;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if (pop || empty) begin
            age_nx = '0;
        end else if (age != AGE_W'(AGE_LIMIT)) begin
            age_nx = age + AGE_W'(1);
        end else begin
            age_nx = age;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= NORMAL;
            stall_q <= FALSE;
            age     <= '0;
        end else begin
            state   <= state_nx;
            stall_q <= stall_nx;
            age     <= age_nx;
        end
    end

    // FSM: next state. DRAIN always lasts a single cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            NORMAL: begin
                if (!empty && !pop &&
                    age == AGE_W'(AGE_LIMIT - 1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN:   state_nx = NORMAL;
            default: state_nx = NORMAL;
        endcase
    end

    // FSM: outputs. Stall is registered alongside the state.
    always_comb begin
        stall_nx = (state_nx == DRAIN);
    end

    // Port D register; key/value hold when nothing is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q    <= FALSE;
            key_q   <= '0;
            value_q <= '0;
        end else begin
            en_q <= grant;
            if (grant) begin
                key_q   <= win_key;
                value_q <= win_value;
            end
        end
    end

    assign bus.a_stall      = stall_q;
    assign bus.portD_enable = en_q;
    assign bus.portD_key    = key_q;
    assign bus.portD_value  = value_q;
    assign bus.fifo_count   = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, directed
// corner sequences, and random traffic against a queue-based model.
module tb_regfile_write_arbiter;

    localparam int DEPTH     = 4;
    localparam int AGE_LIMIT = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

    regfile_write_arbiter #(
        .DEPTH     (DEPTH),
        .AGE_LIMIT (AGE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        sp;
        logic [4:0]  key;
        logic [31:0] val;
    } rec_t;

    typedef struct {
        logic        av;
        logic        asp;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic        bv;
        logic        bsp;
        logic [4:0]  bd;
        logic [31:0] bdat;
        logic        en;
        logic [4:0]  key;
        logic [31:0] val;
        int          cnt;
    } vec_t;

    // Reference model: FIFO as a queue, starvation tracked by the cycle at
    // which the current head started waiting.
    rec_t        q[$];
    int          cyc;
    int          head_since;
    bit          m_stall;
    bit          e_en;
    logic [4:0]  e_key;
    logic [31:0] e_val;

    vec_t tbl[12];

    function automatic bit eff(logic sp, logic [4:0] d);
        return sp ? (d == 5'd0) : (d != 5'd0);
    endfunction

    function automatic vec_t v(int av, int asp, int ad, int adat,
                               int bv, int bsp, int bd, int bdat,
                               int en, int key, int val, int cnt);
        vec_t r;
        r.av   = 1'(av);
        r.asp  = 1'(asp);
        r.ad   = 5'(ad);
        r.adat = 32'(adat);
        r.bv   = 1'(bv);
        r.bsp  = 1'(bsp);
        r.bd   = 5'(bd);
        r.bdat = 32'(bdat);
        r.en   = 1'(en);
        r.key  = 5'(key);
        r.val  = 32'(val);
        r.cnt  = cnt;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_in(int av, int asp, int ad, int adat,
                          int bv, int bsp, int bd, int bdat);
        bus.a_valid      = 1'(av);
        bus.a_is_special = 1'(asp);
        bus.a_dest       = 5'(ad);
        bus.a_data       = 32'(adat);
        bus.b_valid      = 1'(bv);
        bus.b_is_special = 1'(bsp);
        bus.b_dest       = 5'(bd);
        bus.b_data       = 32'(bdat);
    endtask

    task automatic model_reset();
        q.delete();
        m_stall    = 1'b0;
        e_en       = 1'b0;
        e_key      = '0;
        e_val      = '0;
        cyc        = 0;
        head_since = 0;
    endtask

    task automatic model_step();
        bit   was_empty;
        bit   rdy;
        bit   popped;
        bit   nxt_stall;
        rec_t r;
        was_empty = (q.size() == 0);
        rdy       = (q.size() != DEPTH);
        popped    = 1'b0;
        nxt_stall = 1'b0;
        e_en      = 1'b0;
        if (!m_stall && bus.a_valid && eff(bus.a_is_special, bus.a_dest)) begin
            e_en  = 1'b1;
            e_key = bus.a_dest;
            e_val = bus.a_data;
        end else if (q.size() > 0) begin
            r      = q.pop_front();
            popped = 1'b1;
            e_en   = 1'b1;
            e_key  = r.key;
            e_val  = r.val;
        end
        if (!m_stall && !was_empty && !popped &&
            (cyc - head_since) == AGE_LIMIT - 1) begin
            nxt_stall = 1'b1;
        end
        if (bus.b_valid && rdy && eff(bus.b_is_special, bus.b_dest)) begin
            r.sp  = bus.b_is_special;
            r.key = bus.b_dest;
            r.val = bus.b_data;
            q.push_back(r);
        end
        if (popped || was_empty) head_since = cyc + 1;
        m_stall = nxt_stall;
        cyc++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(string tag);
        chk({tag, "_en"},    32'(bus.portD_enable), 32'(e_en));
        chk({tag, "_key"},   32'(bus.portD_key),    32'(e_key));
        chk({tag, "_val"},   bus.portD_value,       e_val);
        chk({tag, "_stall"}, 32'(bus.a_stall),      32'(m_stall));
        chk({tag, "_cnt"},   32'(bus.fifo_count),   32'(q.size()));
        chk({tag, "_rdy"},   32'(bus.b_ready),      32'(q.size() != DEPTH));
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("rst_en",    32'(bus.portD_enable), 32'd0);
        chk("rst_key",   32'(bus.portD_key),    32'd0);
        chk("rst_val",   bus.portD_value,       32'd0);
        chk("rst_stall", 32'(bus.a_stall),      32'd0);
        chk("rst_cnt",   32'(bus.fifo_count),   32'd0);
        chk("rst_rdy",   32'(bus.b_ready),      32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int adest;
        int first_stall;
        int stall_cnt;
        bit stalled_before;
        bit reached;

        tbl[0]  = v(1,0,0,'hDEAD, 1,0,5,'h11,  0,0,0,1);
        tbl[1]  = v(1,0,0,'hDEAD, 1,0,6,'h22,  1,5,'h11,1);
        tbl[2]  = v(0,0,0,0,      0,0,0,0,     1,6,'h22,0);
        tbl[3]  = v(1,1,0,'h55,   0,0,0,0,     1,0,'h55,0);
        tbl[4]  = v(0,0,0,0,      0,0,0,0,     0,0,'h55,0);
        tbl[5]  = v(1,0,3,'hA3,   1,1,4,'hBAD, 1,3,'hA3,0);
        tbl[6]  = v(0,0,0,0,      1,1,0,'hB0,  0,3,'hA3,1);
        tbl[7]  = v(0,0,0,0,      1,0,0,'hBB,  1,0,'hB0,0);
        tbl[8]  = v(0,0,0,0,      1,0,9,'h99,  0,0,'hB0,1);
        tbl[9]  = v(0,0,0,0,      1,0,10,'hAA, 1,9,'h99,1);
        tbl[10] = v(0,0,0,0,      1,0,11,'hBB, 1,10,'hAA,1);
        tbl[11] = v(0,0,0,0,      0,0,0,0,     1,11,'hBB,0);

        // Vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].av, tbl[i].asp, tbl[i].ad, tbl[i].adat,
                   tbl[i].bv, tbl[i].bsp, tbl[i].bd, tbl[i].bdat);
            step();
            chk($sformatf("vec%0d_en", i),
                32'(bus.portD_enable), 32'(tbl[i].en));
            chk($sformatf("vec%0d_key", i),
                32'(bus.portD_key), 32'(tbl[i].key));
            chk($sformatf("vec%0d_val", i), bus.portD_value, tbl[i].val);
            chk($sformatf("vec%0d_cnt", i),
                32'(bus.fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_stall", i), 32'(bus.a_stall), 32'd0);
        end

        // Full FIFO while A is busy every cycle
        do_reset();
        for (int k = 0; k < 6; k++) begin
            int e;
            e = (k < 4) ? k : 4;
            set_in(1, 0, 1, 'h500 + k, 1, 0, 20 + e, 'h100 + e);
            step();
            chk($sformatf("full%0d_cnt", k),
                32'(bus.fifo_count), 32'((k < 3) ? k + 1 : 4));
            chk($sformatf("full%0d_rdy", k),
                32'(bus.b_ready), 32'(k < 3));
            chk($sformatf("full%0d_key", k), 32'(bus.portD_key), 32'd1);
        end

        // Starvation: one B entry behind continuous A traffic
        do_reset();
        adest = 1;
        first_stall = -1;
        stall_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            set_in(1, 0, adest, 'h1000 + adest,
                   (c == 0) ? 1 : 0, 0, 7, 'h77);
            stalled_before = bus.a_stall;
            step();
            if (!stalled_before) adest++;
            if (bus.a_stall) begin
                stall_cnt++;
                if (first_stall < 0) first_stall = c;
            end
            if (c == 8) begin
                chk("starve_c8_key", 32'(bus.portD_key), 32'd9);
            end
            if (c == 9) begin
                chk("starve_drain_en",  32'(bus.portD_enable), 32'd1);
                chk("starve_drain_key", 32'(bus.portD_key), 32'd7);
                chk("starve_drain_val", bus.portD_value, 32'h77);
                chk("starve_drain_cnt", 32'(bus.fifo_count), 32'd0);
            end
            if (c == 10) begin
                chk("starve_resume_key", 32'(bus.portD_key), 32'd10);
                chk("starve_resume_val", bus.portD_value, 32'h100A);
            end
        end
        chk("starve_stall_cycles", 32'(stall_cnt), 32'd1);
        chk("starve_first_stall", 32'(first_stall), 32'd8);

        // Reset asserted during a forced drain
        do_reset();
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            set_in(1, 0, 1, 'h1, (c < 2) ? 1 : 0, 0, 3 + c, 'h30 + c);
            step();
            if (bus.a_stall) reached = 1'b1;
        end
        chk("drain_reached", 32'(reached), 32'd1);
        chk("drain_cnt", 32'(bus.fifo_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_en",    32'(bus.portD_enable), 32'd0);
        chk("midrst_stall", 32'(bus.a_stall),      32'd0);
        chk("midrst_cnt",   32'(bus.fifo_count),   32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("postrst%0d_en", c), 32'(bus.portD_enable), 32'd0);
            chk($sformatf("postrst%0d_cnt", c), 32'(bus.fifo_count), 32'd0);
        end

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(0, 99) < 75) ? 1 : 0,
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   $urandom_range(0, 3), $urandom,
                   ($urandom_range(0, 99) < 35) ? 1 : 0,
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   $urandom_range(0, 7), $urandom);
            step();
            cmp_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
